// File: rtl/alu_8bit.sv
// 8-bit registered ALU (add/sub/and/mul) with a 1-cycle result latency.
// Define ALU_SIGNED_MUL_EN to make opcode 11 a two's-complement multiply.
module alu_8bit #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [1:0]         opcode,
  output logic               out_valid,
  output logic               overflow,
  output logic               carry,
  output logic [WIDTH-1:0]   result,
  output logic [2*WIDTH-1:0] product
);

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_AND = 2'b10,
    OP_MUL = 2'b11
  } op_e;

  op_e                op;
  logic [WIDTH:0]     sum_ext;
  logic [WIDTH:0]     diff_ext;
  logic [2*WIDTH-1:0] mul_full;
  logic               mul_ovf;

  logic               nxt_overflow;
  logic               nxt_carry;
  logic [WIDTH-1:0]   nxt_result;
  logic [2*WIDTH-1:0] nxt_product;

  assign op = op_e'(opcode);

  // The top bit of the widened difference is the unsigned borrow (a < b).
  assign sum_ext  = {1'b0, a} + {1'b0, b};
  assign diff_ext = {1'b0, a} - {1'b0, b};

`ifdef ALU_SIGNED_MUL_EN
  // Sign-extending to 2*WIDTH makes the low 2*WIDTH bits of the product the signed result.
  assign mul_full = {{WIDTH{a[WIDTH-1]}}, a} * {{WIDTH{b[WIDTH-1]}}, b};
  assign mul_ovf  = !((&mul_full[2*WIDTH-1:WIDTH-1]) || !(|mul_full[2*WIDTH-1:WIDTH-1]));
`else
  assign mul_full = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
  assign mul_ovf  = |mul_full[2*WIDTH-1:WIDTH];
`endif

  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latch).
    nxt_overflow = 1'b0;
    nxt_carry    = 1'b0;
    nxt_result   = '0;
    nxt_product  = '0;
    case (op)
      OP_ADD: begin
        nxt_result   = sum_ext[WIDTH-1:0];
        nxt_carry    = sum_ext[WIDTH];
        nxt_overflow = (a[WIDTH-1] == b[WIDTH-1]) && (sum_ext[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        nxt_result   = diff_ext[WIDTH-1:0];
        nxt_carry    = diff_ext[WIDTH];
        nxt_overflow = (a[WIDTH-1] != b[WIDTH-1]) && (diff_ext[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND: begin
        nxt_result = a & b;
      end
      OP_MUL: begin
        nxt_product  = mul_full;
        nxt_result   = mul_full[WIDTH-1:0];
        nxt_overflow = mul_ovf;
      end
      default: ;
    endcase
  end

  // Reset clears everything at once, dropping any result that was about to be registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      overflow  <= 1'b0;
      carry     <= 1'b0;
      result    <= '0;
      product   <= '0;
    end else begin
      // NOTE: non-blocking assignments so all registers update together from pre-edge values.
      out_valid <= in_valid;
      if (in_valid) begin
        overflow <= nxt_overflow;
        carry    <= nxt_carry;
        result   <= nxt_result;
        product  <= nxt_product;
      end
    end
  end

endmodule

// File: tb/tb_alu_8bit.sv
// Scoreboard bench for alu_8bit: driver pushes model expectations, monitor pops and compares.
// Works for both builds; the model follows ALU_SIGNED_MUL_EN like the design.
module tb_alu_8bit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [7:0]  a = '0;
  logic [7:0]  b = '0;
  logic [1:0]  opcode = '0;
  logic        out_valid;
  logic        overflow;
  logic        carry;
  logic [7:0]  result;
  logic [15:0] product;

  typedef struct packed {
    logic        valid;
    logic        ovf;
    logic        cy;
    logic [7:0]  res;
    logic [15:0] prod;
  } exp_t;

  exp_t sb[$];
  exp_t held;
  int   tests = 0;
  int   fails = 0;

  alu_8bit #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .opcode    (opcode),
    .out_valid (out_valid),
    .overflow  (overflow),
    .carry     (carry),
    .result    (result),
    .product   (product)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: plain integer arithmetic on unsigned and signed interpretations.
  function automatic exp_t model(input logic [7:0] ia, input logic [7:0] ib, input logic [1:0] op);
    exp_t e;
    int ua, ub, sa, sb_, r, s, p;
    ua = int'(ia);
    ub = int'(ib);
    sa = (ua >= 128) ? ua - 256 : ua;
    sb_ = (ub >= 128) ? ub - 256 : ub;
    e = '0;
    e.valid = 1'b1;
    case (op)
      2'd0: begin
        r = ua + ub;
        s = sa + sb_;
        e.res = 8'(r);
        e.cy  = (r > 255);
        e.ovf = (s > 127) || (s < -128);
      end
      2'd1: begin
        r = ua - ub;
        s = sa - sb_;
        e.res = 8'(r);
        e.cy  = (ua < ub);
        e.ovf = (s > 127) || (s < -128);
      end
      2'd2: e.res = ia & ib;
      default: begin
`ifdef ALU_SIGNED_MUL_EN
        p = sa * sb_;
        e.ovf = (p > 127) || (p < -128);
`else
        p = ua * ub;
        e.ovf = (p > 255);
`endif
        e.prod = 16'(p);
        e.res  = 8'(p);
      end
    endcase
    return e;
  endfunction

  // Drive one cycle of stimulus on the falling edge and queue what the next rising edge must produce.
  task automatic do_op(input logic v, input logic [7:0] ia, input logic [7:0] ib, input logic [1:0] op);
    exp_t e;
    @(negedge clk);
    in_valid = v;
    a = ia;
    b = ib;
    opcode = op;
    if (v) begin
      held = model(ia, ib, op);
      e = held;
    end else begin
      e = held;
      e.valid = 1'b0;
    end
    sb.push_back(e);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_valid"},   32'(out_valid), 32'h0);
    check({tag, "_ovf"},     32'(overflow),  32'h0);
    check({tag, "_carry"},   32'(carry),     32'h0);
    check({tag, "_result"},  32'(result),    32'h0);
    check({tag, "_product"}, 32'(product),   32'h0);
  endtask

  // Monitor: one sample per cycle, shortly after the rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (!rst) begin
        if (sb.size() == 0) begin
          check("idle_valid", 32'(out_valid), 32'h0);
        end else begin
          e = sb.pop_front();
          check("valid",   32'(out_valid), 32'(e.valid));
          check("ovf",     32'(overflow),  32'(e.ovf));
          check("carry",   32'(carry),     32'(e.cy));
          check("result",  32'(result),    32'(e.res));
          check("product", 32'(product),   32'(e.prod));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    held = '0;
    #1;
    check_zero("por");
    // Reset held with inputs toggling: outputs must stay cleared across edges.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      a = 8'($urandom);
      b = 8'($urandom);
      opcode = 2'($urandom);
      #1;
      check_zero("rst_hold");
    end
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;

    // Directed cases.
    do_op(1'b1, 8'd200, 8'd100, 2'd0);
    do_op(1'b1, 8'd100, 8'd100, 2'd0);
    do_op(1'b1, 8'd5,   8'd10,  2'd1);
    do_op(1'b1, 8'hF0,  8'h3C,  2'd2);
    do_op(1'b0, 8'h12,  8'h34,  2'd3);
    do_op(1'b0, 8'h56,  8'h78,  2'd0);
    do_op(1'b1, 8'hFF,  8'hFF,  2'd3);
    do_op(1'b1, 8'h80,  8'h01,  2'd1);
    do_op(1'b1, 8'h7F,  8'h01,  2'd0);
    do_op(1'b1, 8'h80,  8'h80,  2'd3);
    do_op(1'b1, 8'h10,  8'h08,  2'd3);
    do_op(1'b0, 8'h00,  8'h00,  2'd0);

    // Randomized mix with idle gaps and corner operands.
    for (int i = 0; i < 300; i++) begin
      logic [7:0] ra, rb;
      ra = 8'($urandom);
      rb = 8'($urandom);
      if ($urandom_range(0, 9) == 0) ra = ($urandom_range(0, 1) != 0) ? 8'hFF : 8'h80;
      if ($urandom_range(0, 9) == 0) rb = ($urandom_range(0, 1) != 0) ? 8'h00 : 8'h7F;
      do_op(($urandom_range(0, 4) != 0), ra, rb, 2'($urandom));
    end

    // Back-to-back add, sub, mul, then reset lands before the mul is registered.
    do_op(1'b1, 8'd50,  8'd60, 2'd0);
    do_op(1'b1, 8'd20,  8'd90, 2'd1);
    do_op(1'b1, 8'hC3,  8'h5A, 2'd3);
    #2;
    rst = 1'b1;
    sb.delete();
    held = '0;
    #1;
    check_zero("rst_async");
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      a = 8'($urandom);
      b = 8'($urandom);
      #1;
      check_zero("rst_mid");
    end
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;

    // After release: an idle cycle, then the first valid op appears one cycle later.
    do_op(1'b0, 8'h11, 8'h22, 2'd0);
    do_op(1'b1, 8'hAA, 8'h55, 2'd0);
    do_op(1'b1, 8'h0C, 8'h0D, 2'd3);
    do_op(1'b0, 8'h00, 8'h00, 2'd0);
    do_op(1'b0, 8'h00, 8'h00, 2'd0);
    @(posedge clk);
    #2;
    check("sb_drained", 32'(sb.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
